fifo_rd_streamer: RTL and testbench

- FPGA-side consumer for the read port of the CPU→FPGA async FIFO. Runs in the read clock domain.
- Drives the FIFO read enable and absorbs the FIFO's one-cycle registered read latency.
- Decodes 36-bit framed words and presents a valid/ready packet stream to FPGA logic, with full throughput under back-pressure.
- Detects framing errors and counts them.

---
 rtl/fifo_stream_pkg.sv | 41 ++++
 rtl/stream_skid_buf.sv | 75 +++++++
 rtl/fifo_rd_streamer.sv | 140 ++++++++++++++
 tb/tb_fifo_rd_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_pkg
//  Description : Shared definitions for the FIFO read-side framing decoder:
//                framed-word bit positions, packed word layout, frame FSM
//                state encoding and the byte-count to byte-enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_pkg;

    localparam int SOP_BIT = 35;
    localparam int EOP_BIT = 34;
    localparam int CNT_LO  = 32;

    // 36-bit framed FIFO word, MSB first.
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  bcnt;     // valid bytes - 1, meaningful only with eop
        logic [31:0] payload;
    } fifo_word_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

    // Thermometer byte enables starting at byte 0.
    function automatic logic [3:0] bcnt_to_keep(input logic [1:0] bcnt);
        logic [3:0] keep;
        case (bcnt)
            2'd0:    keep = 4'b0001;
            2'd1:    keep = 4'b0011;
            2'd2:    keep = 4'b0111;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_buf
//  Description : Small circular buffer for valid/ready decoupling. The head
//                entry is presented combinationally from storage registers.
//                Push and pop in the same cycle are accepted at any
//                occupancy, including full.
//  Ports       : clk, rst_n (async, active-low)
//                i_push/i_push_data - enqueue one entry
//                i_pop              - dequeue head (ignored when empty)
//                o_head/o_valid     - head entry and non-empty flag
//                o_count            - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 37
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign o_valid   = (r_count != '0);
    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop & o_valid;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot the write pointer targets.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_streamer
//  Description : Read-side consumer of the CPU->FPGA async FIFO. Issues
//                reads only when the output buffer can absorb the word that
//                returns one cycle later, decodes SOP/EOP framing, and
//                presents a valid/ready stream. Orphan words are dropped and
//                truncated frames flagged; both have saturating counters.
//  Ports       : r_clk, r_rst_n (async, active-low)
//                fifo_data/fifo_empty/fifo_r_en - FIFO read port
//                m_valid/m_ready/m_data/m_keep/m_last - output stream
//                err_orphan_cnt/err_trunc_cnt/err_pulse - framing errors
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH     = 36,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_r_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_data,
    output logic [3:0]           m_keep,
    output logic                 m_last,
    output logic [CNT_WIDTH-1:0] err_orphan_cnt,
    output logic [CNT_WIDTH-1:0] err_trunc_cnt,
    output logic                 err_pulse
);

    localparam int c_ENTRY_W = 37;
    localparam int c_CNT_W   = $clog2(BUF_DEPTH+1);
    localparam int c_OCC_W   = c_CNT_W + 1;

    frame_state_t         r_state;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_orphan_cnt;
    logic [CNT_WIDTH-1:0] r_trunc_cnt;
    logic                 r_err_pulse;

    logic                 w_sop;
    logic                 w_eop;
    logic [1:0]           w_bcnt;
    logic [31:0]          w_payload;
    logic                 w_push;
    logic                 w_orphan;
    logic                 w_trunc;
    frame_state_t         w_state_nxt;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_pop;
    logic [c_OCC_W-1:0]   w_occ;

    assign w_sop     = fifo_data[SOP_BIT];
    assign w_eop     = fifo_data[EOP_BIT];
    assign w_bcnt    = fifo_data[CNT_LO +: 2];
    assign w_payload = fifo_data[CNT_LO-1:0];

    // Occupancy after this edge, counting the slot reserved for the word
    // already in flight. Reading only while this is below depth makes
    // buffer overflow impossible and still allows one word per cycle.
    assign w_pop     = m_valid & m_ready;
    assign w_occ     = c_OCC_W'(w_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    // Gated by reset so the read stops the moment reset asserts.
    assign fifo_r_en = r_rst_n & ~fifo_empty & (w_occ < c_OCC_W'(BUF_DEPTH));

    // Frame decode of the word returning from the FIFO this cycle.
    always_comb begin
        w_push      = 1'b0;
        w_orphan    = 1'b0;
        w_trunc     = 1'b0;
        w_state_nxt = r_state;
        if (r_inflight) begin
            if (w_sop) begin
                w_push      = 1'b1;
                w_trunc     = (r_state == IN_FRAME);
                w_state_nxt = w_eop ? IDLE : IN_FRAME;
            end else if (r_state == IDLE) begin
                w_orphan    = 1'b1;
            end else begin
                w_push      = 1'b1;
                if (w_eop) begin
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    assign w_push_data = {w_payload, (w_eop ? bcnt_to_keep(w_bcnt) : 4'hF), w_eop};

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state      <= IDLE;
            r_inflight   <= 1'b0;
            r_orphan_cnt <= '0;
            r_trunc_cnt  <= '0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_inflight  <= fifo_r_en & ~fifo_empty;
            r_err_pulse <= w_orphan | w_trunc;
            if (w_orphan && (r_orphan_cnt != '1)) begin
                r_orphan_cnt <= r_orphan_cnt + 1'b1;
            end
            if (w_trunc && (r_trunc_cnt != '1)) begin
                r_trunc_cnt <= r_trunc_cnt + 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (c_ENTRY_W)
    ) u_buf (
        .clk         (r_clk),
        .rst_n       (r_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (m_ready),
        .o_head      (w_head),
        .o_valid     (m_valid),
        .o_count     (w_count)
    );

    assign m_data         = w_head[36:5];
    assign m_keep         = w_head[4:1];
    assign m_last         = w_head[0];
    assign err_orphan_cnt = r_orphan_cnt;
    assign err_trunc_cnt  = r_trunc_cnt;
    assign err_pulse      = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_streamer
//  Description : Directed self-checking bench for fifo_rd_streamer. A small
//                registered-read FIFO model feeds the DUT; a negedge monitor
//                records accepted words, error pulses, read throttling and
//                output stability during stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_streamer;
    import fifo_stream_pkg::*;

    localparam int CNTW = 4;

    logic            r_clk   = 1'b0;
    logic            r_rst_n = 1'b0;
    logic [35:0]     fifo_data = '0;
    logic            fifo_empty;
    logic            fifo_r_en;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [31:0]     m_data;
    logic [3:0]      m_keep;
    logic            m_last;
    logic [CNTW-1:0] err_orphan_cnt;
    logic [CNTW-1:0] err_trunc_cnt;
    logic            err_pulse;

    int n_checks = 0;
    int n_errors = 0;

    fifo_rd_streamer #(
        .WIDTH     (36),
        .BUF_DEPTH (2),
        .CNT_WIDTH (CNTW)
    ) dut (
        .r_clk          (r_clk),
        .r_rst_n        (r_rst_n),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_r_en      (fifo_r_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .m_last         (m_last),
        .err_orphan_cnt (err_orphan_cnt),
        .err_trunc_cnt  (err_trunc_cnt),
        .err_pulse      (err_pulse)
    );

    always #5 r_clk = ~r_clk;

    // FIFO model: one-cycle registered read, read pointer reset with r_rst_n.
    logic [35:0] fmem [0:255];
    int wr_idx = 0;
    int rd_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge r_clk) begin
        if (!r_rst_n) begin
            rd_idx <= wr_idx;
        end else if (fifo_r_en && !fifo_empty) begin
            fifo_data <= fmem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    // Monitor
    logic [36:0] outq [$];
    int          out_cyc [$];
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          stall_viol = 0;
    int          throttle_cnt = 0;
    logic        stall_pend = 1'b0;
    logic [36:0] stall_snap = '0;

    always @(negedge r_clk) begin
        cyc = cyc + 1;
        if (stall_pend && (!m_valid || ({m_data, m_keep, m_last} != stall_snap)))
            stall_viol = stall_viol + 1;
        stall_pend = m_valid && !m_ready;
        stall_snap = {m_data, m_keep, m_last};
        if (m_valid && m_ready) begin
            outq.push_back({m_data, m_keep, m_last});
            out_cyc.push_back(cyc);
        end
        if (err_pulse) pulse_cnt = pulse_cnt + 1;
        if (r_rst_n && !fifo_empty && !fifo_r_en) throttle_cnt = throttle_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic sop, input logic eop,
                                       input logic [1:0] bcnt, input logic [31:0] pl);
        fifo_word_t w;
        w.sop = sop; w.eop = eop; w.bcnt = bcnt; w.payload = pl;
        return w;
    endfunction

    function automatic logic [36:0] rec(input logic [31:0] d, input logic [3:0] k, input logic l);
        return {d, k, l};
    endfunction

    task automatic put(input logic [35:0] w);
        fmem[wr_idx] = w;
        wr_idx = wr_idx + 1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge r_clk);
        #1 m_ready = v;
    endtask

    initial begin
        int base;
        int p0;
        int lat;
        int thr0;
        logic [6:0] pat;
        logic [36:0] exp2 [6];

        // Reset state
        repeat (3) @(negedge r_clk);
        #1;
        check("rst_m_valid",   m_valid, 1'b0);
        check("rst_fifo_r_en", fifo_r_en, 1'b0);
        check("rst_outputs",   {m_data, m_keep, m_last}, 37'h0);
        check("rst_counters",  {err_orphan_cnt, err_trunc_cnt, err_pulse}, '0);
        @(negedge r_clk);
        r_rst_n = 1'b1;
        set_ready(1'b1);

        // Single frame with latency measurement
        @(negedge r_clk);
        base = outq.size();
        put(mk(1, 0, 2'd0, 32'hA0A0_0000));
        put(mk(0, 0, 2'd0, 32'hA1A1_1111));
        put(mk(0, 1, 2'd2, 32'hA2A2_2222));
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge r_clk);
            lat++;
        end
        check("t1_latency", lat, 2);
        repeat (6) @(negedge r_clk);
        #2;
        check("t1_count", outq.size() - base, 3);
        if (outq.size() >= base + 3) begin
            check("t1_w0", outq[base],   rec(32'hA0A0_0000, 4'hF, 1'b0));
            check("t1_w1", outq[base+1], rec(32'hA1A1_1111, 4'hF, 1'b0));
            check("t1_w2", outq[base+2], rec(32'hA2A2_2222, 4'b0111, 1'b1));
            check("t1_back_to_back", out_cyc[base+2] - out_cyc[base], 2);
        end

        // Back-pressure, 6-word frame, ready pattern 1,0,0,1,1,0,1 repeating
        pat  = 7'b1011001;
        thr0 = throttle_cnt;
        for (int i = 0; i < 6; i++)
            exp2[i] = rec(32'hB000_0000 + 32'(i), (i == 5) ? 4'b0001 : 4'hF, i == 5);
        @(negedge r_clk);
        base = outq.size();
        put(mk(1, 0, 2'd0, 32'hB000_0000));
        for (int i = 1; i < 5; i++) put(mk(0, 0, 2'd0, 32'hB000_0000 + 32'(i)));
        put(mk(0, 1, 2'd0, 32'hB000_0005));
        for (int i = 0; i < 120 && outq.size() < base + 6; i++) begin
            @(posedge r_clk);
            #1 m_ready = pat[i % 7];
        end
        set_ready(1'b1);
        repeat (4) @(negedge r_clk);
        #2;
        check("t2_count", outq.size() - base, 6);
        if (outq.size() >= base + 6)
            for (int i = 0; i < 6; i++) check($sformatf("t2_w%0d", i), outq[base+i], exp2[i]);
        check("t2_stall_stable", stall_viol, 0);
        check("t2_read_throttled", (throttle_cnt > thr0), 1'b1);

        // Orphan word in IDLE
        @(negedge r_clk);
        base = outq.size();
        p0   = pulse_cnt;
        put(mk(0, 0, 2'd0, 32'h0000_DEAD));
        repeat (6) @(negedge r_clk);
        #2;
        check("t3_no_output", outq.size() - base, 0);
        check("t3_orphan_cnt", err_orphan_cnt, 4'd1);
        check("t3_trunc_cnt", err_trunc_cnt, 4'd0);
        check("t3_pulses", pulse_cnt - p0, 1);

        // Truncated frame
        @(negedge r_clk);
        base = outq.size();
        p0   = pulse_cnt;
        put(mk(1, 0, 2'd0, 32'hC0C0_C0C0));
        put(mk(0, 0, 2'd0, 32'hC1C1_C1C1));
        put(mk(1, 1, 2'd3, 32'h0000_1234));
        repeat (8) @(negedge r_clk);
        #2;
        check("t4_count", outq.size() - base, 3);
        if (outq.size() >= base + 3) begin
            check("t4_w0", outq[base],   rec(32'hC0C0_C0C0, 4'hF, 1'b0));
            check("t4_w1", outq[base+1], rec(32'hC1C1_C1C1, 4'hF, 1'b0));
            check("t4_w2", outq[base+2], rec(32'h0000_1234, 4'hF, 1'b1));
        end
        check("t4_trunc_cnt", err_trunc_cnt, 4'd1);
        check("t4_orphan_cnt", err_orphan_cnt, 4'd1);
        check("t4_pulses", pulse_cnt - p0, 1);

        // Saturation: 20 more orphans on a 4-bit counter
        @(negedge r_clk);
        base = outq.size();
        p0   = pulse_cnt;
        for (int i = 0; i < 20; i++) put(mk(0, 0, 2'd0, 32'h5A00_0000 + 32'(i)));
        repeat (30) @(negedge r_clk);
        #2;
        check("t5_orphan_sat", err_orphan_cnt, 4'hF);
        check("t5_pulses", pulse_cnt - p0, 20);
        check("t5_no_output", outq.size() - base, 0);

        // Reset mid-frame with the buffer full and words still in the FIFO
        set_ready(1'b0);
        @(negedge r_clk);
        put(mk(1, 0, 2'd0, 32'hD000_0000));
        put(mk(0, 0, 2'd0, 32'hD000_0001));
        put(mk(0, 0, 2'd0, 32'hD000_0002));
        put(mk(0, 0, 2'd0, 32'hD000_0003));
        repeat (6) @(negedge r_clk);
        #1;
        check("t6_pre_valid", m_valid, 1'b1);
        r_rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", m_valid, 1'b0);
        check("t6_rst_fifo_r_en", fifo_r_en, 1'b0);
        check("t6_rst_counters", {err_orphan_cnt, err_trunc_cnt, err_pulse}, '0);
        repeat (2) @(negedge r_clk);
        r_rst_n = 1'b1;
        set_ready(1'b1);
        @(negedge r_clk);
        base = outq.size();
        p0   = pulse_cnt;
        put(mk(0, 0, 2'd0, 32'h0000_E0E0));
        repeat (6) @(negedge r_clk);
        #2;
        check("t6_no_output", outq.size() - base, 0);
        check("t6_orphan_after_rst", err_orphan_cnt, 4'd1);
        check("t6_pulses", pulse_cnt - p0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
